program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
Fetch-stage program counter for a superscalar front end that fetches CORE_WIDTH instructions per cycle. It holds a registered next-fetch address `next_pc`. Each clock it does one of three things: advances `next_pc` by one fetch-bundle width, holds it for a stall, or loads a redirect target from a branch, jump or flush. It sits at the head of the fetch pipeline and drives the instruction-memory fetch address.

Parameters:
- CORE_WIDTH, 2, instructions fetched per cycle (>=1).
- INSN_BYTES, 4, bytes per instruction.
- RESET_PC, 32'h0000_0000, architectural start address; `next_pc` resets to RESET_PC + CORE_WIDTH*INSN_BYTES.
- Derived localparam STEP = CORE_WIDTH*INSN_BYTES (8 with defaults), truncated to 32 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- hold_pc  input  1  stall: keep `next_pc` unchanged this cycle.
- redirect_enable  input  1  load `redirect_addr` this cycle; overrides `hold_pc`.
- redirect_addr  input  32  redirect target byte address.
- next_pc  output  32  registered next fetch address.

Behaviour:
- Single 32-bit register drives `next_pc` directly. No combinational path from any input to `next_pc`.
- Priority at each rising clk edge:
  - reset=1 -> `next_pc` <= RESET_PC + STEP (8 with defaults). reset has highest priority.
  - else redirect_enable=1 -> `next_pc` <= redirect_addr. This applies regardless of hold_pc.
  - else hold_pc=1 -> `next_pc` <= `next_pc`.
  - else -> `next_pc` <= `next_pc` + STEP, modulo 2^32. Wrap-around is silent: 32'hFFFF_FFF8 + 8 -> 32'h0.
- Latency:
  - Redirect visible on `next_pc` one cycle after the edge that samples it.
  - Hold and increment effects are likewise visible one cycle after their sampling edge.
- Reset:
  - Value is established within the first edge with reset=1 and persists while reset stays high.
  - The first edge after reset deasserts applies normal priority. Example: with no hold or redirect, 8 -> 16.
  - Reset asserted mid-operation discards any pending hold or redirect on that edge.
- redirect_addr is loaded verbatim. No alignment masking or checking; callers supply 4-byte-aligned targets.
- Inputs are sampled only at rising clk. Changes between edges have no effect.
- No X-propagation tolerance required on control inputs after reset. Bench drives known values.

Test Plan:
1. Reset: hold reset=1 for 2 edges with hold_pc=0, redirect_enable=0, then deassert -> `next_pc`=32'h8 immediately after release. The next 5 edges give 0x10, 0x18, 0x20, 0x28, 0x30.
2. Hold: from 0x30 with hold_pc=1 for 2 edges -> `next_pc` stays 0x30. Release -> 0x38, then 0x40.
3. Redirect: from 0x40 with redirect_enable=1, redirect_addr=0x10 -> `next_pc`=0x10. Deassert -> 0x18.
4. Redirect beats hold: redirect_enable=1, hold_pc=1, redirect_addr=0x10 -> `next_pc`=0x10. Then redirect_enable=0 with hold_pc=1 -> stays 0x10.
5. Wrap and mid-run reset: redirect to 0xFFFF_FFF8, then one free edge -> 0x0000_0000. Assert reset for one edge while redirect_enable=1 -> `next_pc`=0x8.
6. Random stress: 50+ cycles with ~20% hold, ~10% redirect to random aligned addresses. The reference model (redirect > hold > +8) must match `next_pc` every cycle.

Source files
------------

// File: rtl/program_counter.sv
// Fetch-stage program counter: holds the registered next-fetch address and
// each cycle advances it by one fetch bundle, stalls, or loads a redirect.
module program_counter #(
  parameter int unsigned CORE_WIDTH = 2,
  parameter int unsigned INSN_BYTES = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold_pc,
  input  logic        redirect_enable,
  input  logic [31:0] redirect_addr,
  output logic [31:0] next_pc
);

  localparam logic [31:0] STEP = 32'(CORE_WIDTH * INSN_BYTES);

  // Priority is reset > redirect > hold > advance; the advance wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc <= RESET_PC + STEP;
    end else if (redirect_enable) begin
      next_pc <= redirect_addr;
    end else if (!hold_pc) begin
      next_pc <= next_pc + STEP;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of program_counter against an
// arithmetic reference model of the fetch address.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        hold_pc;
  logic        redirect_enable;
  logic [31:0] redirect_addr;
  logic [31:0] next_pc;

  int          checks;
  int          errors;
  logic [31:0] model_pc;

  program_counter #(
    .CORE_WIDTH(2),
    .INSN_BYTES(4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hold_pc        (hold_pc),
    .redirect_enable(redirect_enable),
    .redirect_addr  (redirect_addr),
    .next_pc        (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] expected);
    checks++;
    assert (next_pc === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, next_pc, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic applyStimulus(input logic r, input logic h, input logic re,
                               input logic [31:0] addr);
    longint sum;
    reset           = r;
    hold_pc         = h;
    redirect_enable = re;
    redirect_addr   = addr;
    @(posedge clk);
    #1;
    if (r) begin
      model_pc = 32'd8;
    end else if (re) begin
      model_pc = addr;
    end else if (!h) begin
      sum      = (longint'(model_pc) + 64'd8) % 64'h1_0000_0000;
      model_pc = sum[31:0];
    end
  endtask

  initial begin
    logic [31:0] raw;
    logic [31:0] rand_addr;
    int          roll;
    logic        rr;
    logic        rh;
    logic        rre;

    checks          = 0;
    errors          = 0;
    model_pc        = 32'd0;
    reset           = 1'b1;
    hold_pc         = 1'b0;
    redirect_enable = 1'b0;
    redirect_addr   = 32'd0;

    // Reset held for two edges, then released.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("reset_edge1", 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("reset_edge2", 32'h8);
    reset = 1'b0;
    #2;
    checkOutput("reset_release", 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_10", 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_18", 32'h18);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_20", 32'h20);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_28", 32'h28);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_30", 32'h30);

    // Stall for two edges.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("hold_1", 32'h30);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("hold_2", 32'h30);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("hold_release_38", 32'h38);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_40", 32'h40);

    // Plain redirect.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10);
    checkOutput("redirect_10", 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after_redirect_18", 32'h18);

    // Redirect overrides hold; hold alone then keeps the target.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h10);
    checkOutput("redirect_over_hold", 32'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("hold_after_redirect", 32'h10);

    // A redirect pulse that falls between edges must be ignored.
    redirect_enable = 1'b1;
    redirect_addr   = 32'h1234_0000;
    hold_pc         = 1'b0;
    #2;
    redirect_enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("between_edges_ignored", 32'h18);

    // Wrap at the top of the address space, then reset beats redirect.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    checkOutput("redirect_top", 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_to_zero", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4000);
    checkOutput("reset_over_redirect", 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_after_reset", 32'h10);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      roll      = int'($urandom_range(0, 99));
      raw       = $urandom;
      rand_addr = {raw[31:2], 2'b00};
      rr        = (roll < 3);
      rre       = (roll >= 3 && roll < 13);
      rh        = ($urandom_range(0, 99) < 20);
      applyStimulus(rr, rh, rre, rand_addr);
      checkOutput($sformatf("random_%0d", i), model_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
